imem_loader: RTL and testbench

- Byte-stream program loader. It is the write side of the instruction memory, which the core only reads.
- Accepts a framed byte stream over a valid/ready handshake and assembles little-endian 32-bit words.
- Writes each word into the instruction memory write port and holds the core in reset until the image is loaded and its checksum verified.
- Sits beside the processor top, between an external byte source (UART RX, testbench) and the instruction memory.

---
 rtl/imem_loader.sv | 96 +++++++++
 tb/tb_imem_loader.sv | 146 ++++++++++++++
 2 files changed

// File: rtl/imem_loader.sv
// imem_loader: assembles a framed little-endian byte stream into instruction memory words,
// then releases the core once the payload XOR checksum matches.
module imem_loader #(
    parameter int ADDR_WIDTH = 32,
    parameter logic [ADDR_WIDTH-1:0] BASE_ADDR = '0,
    parameter int LEN_WIDTH = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [7:0]            rx_data,
    input  logic                  rx_valid,
    output logic                  rx_ready,
    output logic                  imem_we,
    output logic [ADDR_WIDTH-1:0] imem_addr,
    output logic [31:0]           imem_wdata,
    output logic                  core_rst,
    output logic                  done,
    output logic                  error,
    output logic [LEN_WIDTH-1:0]  words_written
);
    typedef enum logic [2:0] {IDLE, LEN_LO, LEN_HI, DATA, CHECK, DONE, ERROR} state_t;
    state_t state, next;
    logic xfer, last_word, idle_like;
    logic [LEN_WIDTH-1:0] len, len_hi;
    logic [1:0] idx;
    logic [23:0] buffer;
    logic [7:0] chk;
    always_comb begin
        rx_ready = state inside {LEN_LO, LEN_HI, DATA, CHECK};
        idle_like = state inside {IDLE, DONE, ERROR};
        xfer = rx_valid && rx_ready;
        len_hi = len | (LEN_WIDTH'(rx_data) << 8);
        last_word = (words_written + LEN_WIDTH'(1)) == len;
        next = state;
        case (state)
            IDLE, DONE, ERROR: next = start ? LEN_LO : state;
            LEN_LO: next = xfer ? LEN_HI : state;
            LEN_HI: next = !xfer ? state : (len_hi == '0 ? CHECK : DATA);
            DATA: next = (xfer && idx == 2'd3 && last_word) ? CHECK : state;
            CHECK: next = !xfer ? state : (rx_data == chk ? DONE : ERROR);
            default: next = IDLE;
        endcase
    end
    always_ff @(posedge clk) state <= !rst ? IDLE : next;
    always_ff @(posedge clk) begin
        if (!rst) begin
            imem_we <= 1'b0;
            imem_addr <= BASE_ADDR;
            imem_wdata <= '0;
            core_rst <= 1'b0;
            done <= 1'b0;
            error <= 1'b0;
            words_written <= '0;
            len <= '0;
            idx <= '0;
            buffer <= '0;
            chk <= '0;
        end else begin
            imem_we <= 1'b0;
            if (start && idle_like) begin
                done <= 1'b0;
                error <= 1'b0;
                core_rst <= 1'b0;
                words_written <= '0;
                chk <= '0;
                idx <= '0;
            end
            if (xfer) begin
                case (state)
                    LEN_LO: len <= LEN_WIDTH'(rx_data);
                    LEN_HI: len <= len_hi;
                    DATA: begin
                        chk <= chk ^ rx_data;
                        idx <= idx + 2'd1;
                        // The fourth byte goes straight to the write port; only three bytes are buffered.
                        if (idx == 2'd3) begin
                            imem_we <= 1'b1;
                            imem_wdata <= {rx_data, buffer};
                            imem_addr <= BASE_ADDR + ADDR_WIDTH'({words_written, 2'b00});
                            words_written <= words_written + LEN_WIDTH'(1);
                        end else begin
                            buffer[{idx, 3'b000} +: 8] <= rx_data;
                        end
                    end
                    CHECK: begin
                        done <= rx_data == chk;
                        core_rst <= rx_data == chk;
                        error <= rx_data != chk;
                    end
                    default: ;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_imem_loader.sv
// tb_imem_loader: directed frames checked against a word-level model of the expected memory writes.
module tb_imem_loader;
    logic clk = 0, rst = 0, start = 0, rx_valid = 0;
    logic [7:0] rx_data = 0;
    logic rx_ready, imem_we, core_rst, done, error;
    logic [31:0] imem_addr, imem_wdata;
    logic [15:0] words_written;

    imem_loader dut (
        .clk(clk), .rst(rst), .start(start), .rx_data(rx_data), .rx_valid(rx_valid),
        .rx_ready(rx_ready), .imem_we(imem_we), .imem_addr(imem_addr), .imem_wdata(imem_wdata),
        .core_rst(core_rst), .done(done), .error(error), .words_written(words_written)
    );

    always #5 clk = ~clk;

    typedef struct {logic [31:0] a; logic [31:0] d;} wr_t;
    wr_t exp_q[$];
    wr_t log_q[$];
    int checks = 0, fails = 0;
    logic [7:0] good[$] = '{8'h13, 8'h00, 8'h00, 8'h00, 8'h93, 8'h00, 8'h10, 8'h00};
    logic [7:0] empty_q[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        wr_t e;
        check("core_rst_eq_done", {31'd0, core_rst}, {31'd0, done});
        check("done_error_excl", {31'd0, done & error}, 32'd0);
        if (imem_we) begin
            log_q.push_back('{imem_addr, imem_wdata});
            if (exp_q.size() == 0) check("unexpected_write", imem_addr, 32'hxxxx_xxxx);
            else begin
                e = exp_q.pop_front();
                check("write_addr", imem_addr, e.a);
                check("write_data", imem_wdata, e.d);
            end
        end
    end

    task automatic send_byte(input logic [7:0] b, input int gap);
        int n = 0;
        rx_valid = 0;
        repeat (gap) begin @(posedge clk); #1; end
        rx_data = b;
        rx_valid = 1;
        while (!rx_ready && n < 50) begin @(posedge clk); #1; n++; end
        check("rx_ready_wait", {31'd0, rx_ready}, 32'd1);
        @(posedge clk); #1;
        rx_valid = 0;
    endtask

    task automatic pulse_start();
        @(posedge clk); #1 start = 1;
        @(posedge clk); #1 start = 0;
    endtask

    task automatic run_frame(input logic [7:0] pay[$], input logic [7:0] ck, input int gap, input string tag);
        logic [7:0] x = 0;
        int n = pay.size() / 4;
        for (int k = 0; k < n; k++)
            exp_q.push_back('{32'(4 * k), {pay[4*k+3], pay[4*k+2], pay[4*k+1], pay[4*k]}});
        foreach (pay[j]) x ^= pay[j];
        pulse_start();
        send_byte(n[7:0], gap);
        send_byte(n[15:8], gap);
        foreach (pay[j]) send_byte(pay[j], gap);
        send_byte(ck, gap);
        repeat (2) @(posedge clk);
        #1;
        check({tag, "_done"}, {31'd0, done}, {31'd0, x == ck});
        check({tag, "_error"}, {31'd0, error}, {31'd0, x != ck});
        check({tag, "_core_rst"}, {31'd0, core_rst}, {31'd0, x == ck});
        check({tag, "_words"}, {16'd0, words_written}, 32'(n));
        check({tag, "_pending"}, 32'(exp_q.size()), 32'd0);
        check({tag, "_rx_ready"}, {31'd0, rx_ready}, 32'd0);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_core_rst"}, {31'd0, core_rst}, 32'd0);
        check({tag, "_rx_ready"}, {31'd0, rx_ready}, 32'd0);
        check({tag, "_we"}, {31'd0, imem_we}, 32'd0);
        check({tag, "_done"}, {31'd0, done}, 32'd0);
        check({tag, "_error"}, {31'd0, error}, 32'd0);
        check({tag, "_addr"}, imem_addr, 32'd0);
        check({tag, "_wdata"}, imem_wdata, 32'd0);
        check({tag, "_words"}, {16'd0, words_written}, 32'd0);
    endtask

    initial begin
        repeat (5) @(posedge clk);
        #1;
        check_reset_outputs("reset");
        rst = 1;

        log_q.delete();
        run_frame(good, 8'h90, 0, "good");
        check("good_nwrites", 32'(log_q.size()), 32'd2);
        if (log_q.size() == 2) begin
            check("good_w0_addr", log_q[0].a, 32'h0);
            check("good_w0_data", log_q[0].d, 32'h0000_0013);
            check("good_w1_addr", log_q[1].a, 32'h4);
            check("good_w1_data", log_q[1].d, 32'h0010_0093);
        end

        log_q.delete();
        run_frame(good, 8'h91, 0, "bad");
        check("bad_nwrites", 32'(log_q.size()), 32'd2);
        run_frame(good, 8'h90, 0, "retry");

        log_q.delete();
        run_frame(good, 8'h90, 3, "gap");
        check("gap_nwrites", 32'(log_q.size()), 32'd2);

        log_q.delete();
        run_frame(empty_q, 8'h00, 0, "empty");
        check("empty_nwrites", 32'(log_q.size()), 32'd0);

        log_q.delete();
        exp_q.push_back('{32'h0, 32'h0000_0013});
        pulse_start();
        send_byte(8'h02, 0);
        send_byte(8'h00, 0);
        for (int j = 0; j < 6; j++) send_byte(good[j], 0);
        rst = 0;
        repeat (2) @(posedge clk);
        #1;
        check_reset_outputs("abort");
        check("abort_nwrites", 32'(log_q.size()), 32'd1);
        check("abort_pending", 32'(exp_q.size()), 32'd0);
        rst = 1;
        log_q.delete();
        run_frame(good, 8'h90, 0, "fresh");
        check("fresh_nwrites", 32'(log_q.size()), 32'd2);
        if (log_q.size() > 0) check("fresh_w0_addr", log_q[0].a, 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end
endmodule
